// File: rtl/rtc_lector.sv
// rtc_lector: read sweep over the nine RTC time/date/timer registers.
// A start pulse in IDLE walks the multiplexed AD bus through an
// address-latch cycle and a read cycle for each register and stores the
// returned byte in a dedicated output register. Every output is a flop;
// the bus controls are computed from the next state so that they line up
// exactly with the state register.
module rtc_lector #(
    parameter logic [11:0] T_PHASE = 12'h04a
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] seg_t,
    output logic [7:0] min_t,
    output logic [7:0] hora_t
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_REL = 3'd2,
        S_READ     = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd8;

    // Register address for each sweep slot, in the order they are read.
    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        phase_end_s;

    logic [7:0]  ad_out_q, ad_out_d;
    logic        ad_oe_q, ad_oe_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        a_d_q, a_d_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  data_q [9];
    logic [7:0]  data_d [9];

    assign phase_end_s = (cnt_q == (T_PHASE - 12'd1));

    // Sequencer: phase counting, state advance and sweep index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 12'd0;
                if (start) begin
                    state_d = S_ADDR;
                    idx_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR, S_ADDR_REL, S_READ: begin
                if (phase_end_s) begin
                    cnt_d = 12'd0;
                    if (state_q == S_ADDR) begin
                        state_d = S_ADDR_REL;
                    end else if (state_q == S_ADDR_REL) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_GAP: begin
                if (phase_end_s) begin
                    cnt_d = 12'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ADDR;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DONE: begin
                cnt_d   = 12'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 12'd0;
                idx_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status levels for the upcoming state, registered below.
    always_comb begin
        ad_out_d = ad_out_q;
        ad_oe_d  = 1'b0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_IDLE: begin
                ad_out_d = 8'h00;
            end
            S_ADDR: begin
                ad_out_d = addr_of(idx_d);
                ad_oe_d  = 1'b1;
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                busy_d   = 1'b1;
            end
            S_ADDR_REL: begin
                ad_out_d = addr_of(idx_d);
                ad_oe_d  = 1'b1;
                a_d_d    = 1'b0;
                busy_d   = 1'b1;
            end
            S_READ: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
                busy_d = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                ad_out_d = 8'h00;
            end
        endcase
    end

    // Capture the returned byte only on the final cycle of the read phase.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            data_d[i] = data_q[i];
        end
        if ((state_q == S_READ) && phase_end_s) begin
            for (int i = 0; i < 9; i++) begin
                if (idx_q == 4'(i)) begin
                    data_d[i] = ad_in;
                end else begin
                    data_d[i] = data_q[i];
                end
            end
        end else begin
            data_d[0] = data_q[0];
        end
    end

    // Sequencer and output registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 12'd0;
            idx_q    <= 4'd0;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Captured register file; cleared by reset, held between sweeps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                data_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign cs_n   = cs_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign a_d    = a_d_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign seg    = data_q[0];
    assign min    = data_q[1];
    assign hora   = data_q[2];
    assign dia    = data_q[3];
    assign mes    = data_q[4];
    assign anio   = data_q[5];
    assign seg_t  = data_q[6];
    assign min_t  = data_q[7];
    assign hora_t = data_q[8];

endmodule

// File: tb/tb_rtc_lector.sv
// tb_rtc_lector: drives sweeps against a behavioural RTC bus model and
// compares captured registers, status timing and bus protocol with
// expectations derived from the register map and phase timing.
module tb_rtc_lector;

    localparam logic [11:0] TP = 12'd4;
    localparam int SWEEP = 36 * 4 + 1; // cycle offset of done after start edge

    localparam logic [7:0] ADDR_TAB [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                            8'h26, 8'h41, 8'h42, 8'h43};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
    logic [7:0] seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t;
    logic [7:0] dout [9];

    int checks   = 0;
    int failures = 0;

    // RTC model knobs
    logic [7:0] latched = 8'h00;
    int         rd_cyc  = 0;
    bit         force4  = 1'b0;
    bit         garbage = 1'b0;
    logic [7:0] off     = 8'h10;

    // monitor state
    bit mon_en    = 1'b0;
    int prev_code = 0;
    int run_len   = 0;
    int addr_pos  = 0;

    rtc_lector #(.T_PHASE(TP)) dut (
        .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n),
        .wr_n(wr_n), .a_d(a_d), .busy(busy), .done(done),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes),
        .anio(anio), .seg_t(seg_t), .min_t(min_t), .hora_t(hora_t)
    );

    assign dout[0] = seg;   assign dout[1] = min;   assign dout[2] = hora;
    assign dout[3] = dia;   assign dout[4] = mes;   assign dout[5] = anio;
    assign dout[6] = seg_t; assign dout[7] = min_t; assign dout[8] = hora_t;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Value the RTC returns on read cycle c of register a.
    function automatic logic [7:0] model_read(input logic [7:0] a, input int c);
        if (force4 && a == 8'h22) return (c < 3) ? 8'hAA : 8'h47;
        if (garbage && c < int'(TP) - 1) return 8'($urandom);
        return a + off;
    endfunction

    // Value the lector should end up holding for register a.
    function automatic logic [7:0] exp_reg(input logic [7:0] a);
        if (force4 && a == 8'h22) return 8'h47;
        return a + off;
    endfunction

    // RTC bus model: latch the address, answer reads, scribble when idle.
    always @(negedge clk) begin
        if (!cs_n && !wr_n && !a_d) latched = ad_out;
        if (!rd_n) begin
            ad_in = model_read(latched, rd_cyc);
            rd_cyc++;
        end else begin
            rd_cyc = 0;
            ad_in  = 8'($urandom);
        end
    end

    // Protocol monitor: invariants, phase order, phase lengths, address order.
    always @(negedge clk) begin
        int c;
        int exp_next;
        if (!busy)                 c = 0;
        else if (done)             c = 5;
        else if (!a_d && !cs_n)    c = 1;
        else if (!a_d)             c = 2;
        else if (!rd_n)            c = 3;
        else                       c = 4;
        if (mon_en) begin
            check_eq("inv_oe_rd", 32'(ad_oe && !rd_n), 32'd0);
            check_eq("inv_wr_addr", 32'(!wr_n && c != 1), 32'd0);
            check_eq("inv_rd_wr", 32'(!rd_n && !wr_n), 32'd0);
            check_eq("inv_ad_low", 32'(!a_d && !(c == 1 || c == 2)), 32'd0);
        end
        if (c == prev_code) begin
            run_len++;
        end else begin
            if (mon_en) begin
                if (prev_code >= 1 && prev_code <= 4)
                    check_eq("phase_len", 32'(run_len), 32'(TP));
                case (prev_code)
                    0: exp_next = 1;
                    1: exp_next = 2;
                    2: exp_next = 3;
                    3: exp_next = 4;
                    4: exp_next = (addr_pos >= 9) ? 5 : 1;
                    default: exp_next = 0;
                endcase
                check_eq("phase_seq", 32'(c), 32'(exp_next));
            end
            if (c == 1) begin
                if (prev_code == 0) addr_pos = 0;
                if (mon_en) begin
                    if (addr_pos < 9) check_eq("addr_order", 32'(ad_out), 32'(ADDR_TAB[addr_pos]));
                    else              check_eq("addr_count", 32'(addr_pos), 32'd8);
                end
                addr_pos++;
            end
            run_len   = 1;
            prev_code = c;
        end
    end

    task automatic check_regs(input string tag);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("%s_r%0h", tag, ADDR_TAB[i]), 32'(dout[i]), 32'(exp_reg(ADDR_TAB[i])));
    endtask

    // One sweep from a negedge: start sampled at the next edge (edge k).
    task automatic do_sweep(input bit extra, input string tag);
        int dones = 0;
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 149; n++) begin
            start = extra && (n == 20 || n == SWEEP);
            check_eq($sformatf("%s_busy", tag), 32'(busy), 32'(n <= SWEEP));
            check_eq($sformatf("%s_done", tag), 32'(done), 32'(n == SWEEP));
            dones += int'(done);
            if (n < 149) @(negedge clk);
        end
        start = 1'b0;
        check_eq($sformatf("%s_ndone", tag), 32'(dones), 32'd1);
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        int w;
        reset = 1'b0;
        start = 1'b0;
        ad_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // reset state
        for (int i = 0; i < 9; i++) check_eq("rst_data", 32'(dout[i]), 32'd0);
        check_eq("rst_bus", {ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, busy, done}, {8'h00, 7'b0111100});
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // basic sweep, address + 0x10
        off = 8'h10; garbage = 1'b0; force4 = 1'b0;
        do_sweep(1'b0, "basic");

        // bus value changing during the read of 0x22
        force4 = 1'b1;
        do_sweep(1'b0, "late");
        force4 = 1'b0;

        // start pulses during the sweep and in DONE are ignored, then a new one launches
        off = 8'h33;
        do_sweep(1'b1, "ign");
        off = 8'h5c;
        do_sweep(1'b0, "relaunch");

        // randomized sweeps with random data and noisy early read cycles
        garbage = 1'b1;
        for (int s = 0; s < 3; s++) begin
            off = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_sweep(1'b0, $sformatf("rand%0d", s));
        end

        // asynchronous reset in the middle of reading 0x23
        off = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(!rd_n && ad_out == 8'h23) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_eq("reach_read23", 32'(w < 300), 32'd1);
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) check_eq("arst_data", 32'(dout[i]), 32'd0);
        check_eq("arst_bus", {ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, busy, done}, {8'h00, 7'b0111100});
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_eq("post_rst_idle", {cs_n, rd_n, wr_n, ad_oe, busy}, 5'b11100);
        end
        mon_en = 1'b1;
        off = 8'($urandom);
        do_sweep(1'b0, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound in case the run loses its way.
    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rtc_lector.md
Name: rtc_lector

Overview:
- Read-side counterpart of the RTC initialization sequencer.
- On a `start` pulse it sweeps the RTC's multiplexed address/data bus over the nine time/timer registers: 0x21–0x26 and 0x41–0x43.
- Each register gets a full address-latch + read cycle; the returned byte is captured into a dedicated output register.
- Feeds the display/formatting logic with the current time, date and timer values. One sweep per request; no autonomous polling.

Parameters:
- T_PHASE, 12'h04a, clock cycles per bus phase. Legal range 2..4095.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  sweep request, sampled only in IDLE
- ad_in  in  8  data read back from the RTC AD bus
- ad_out  out  8  address value driven onto the AD bus
- ad_oe  out  1  1 = drive ad_out onto the bus (tristate enable)
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe, active low
- wr_n  out  1  RTC write strobe, active low
- a_d  out  1  0 = address phase, 1 = data phase
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- seg, min, hora  out  8 each  regs 0x21, 0x22, 0x23
- dia, mes, anio  out  8 each  regs 0x24, 0x25, 0x26
- seg_t, min_t, hora_t  out  8 each  regs 0x41, 0x42, 0x43

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all nine data registers = 8'h00.
  - ad_out = 0, ad_oe = 0, cs_n = 1, rd_n = 1, wr_n = 1, a_d = 1, busy = 0, done = 0.
  - Phase counter = 0, register index = 0.
  - Reset asserted mid-sweep aborts the sweep; no partial capture survives.
- FSM states: IDLE, ADDR, ADDR_REL, READ, GAP, DONE.
- All outputs are registered.
- Phase counter runs 0..T_PHASE-1. Each of ADDR/ADDR_REL/READ/GAP lasts exactly T_PHASE cycles. The counter clears on every phase change.
- IDLE:
  - Bus inactive (reset levels).
  - start = 1 at a rising edge → ADDR next cycle, index = 0, busy = 1.
- ADDR:
  - cs_n = 0, wr_n = 0, a_d = 0, ad_oe = 1, ad_out = table[index].
  - Address table: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
- ADDR_REL: cs_n = 1, wr_n = 1, a_d = 0, ad_oe = 1, ad_out held.
- READ:
  - cs_n = 0, rd_n = 0, a_d = 1, ad_oe = 0.
  - ad_in is captured into the indexed register only at the edge ending the last cycle (counter = T_PHASE-1). Earlier bus values are ignored.
- GAP:
  - cs_n = 1, rd_n = 1, a_d = 1, ad_oe = 0.
  - At the end of GAP: index < 8 → index+1, ADDR. Index = 8 → DONE.
- DONE: exactly one cycle; done = 1, busy = 1. Then IDLE (busy = 0, done = 0).
- Sweep latency: start edge k → DONE in cycle k + 1 + 36·T_PHASE.
- start while not IDLE (including DONE) is ignored; it is not queued.
- Data registers hold their values between sweeps. Only the register being read changes, and only at its capture edge.
- Invariants:
  - ad_oe = 1 never coincides with rd_n = 0.
  - wr_n = 0 only in ADDR.
  - rd_n and wr_n are never both low.
  - a_d = 0 only in ADDR/ADDR_REL.

Test Plan:
1. Assert reset with clk running, release → all data outputs 0x00, cs_n = rd_n = wr_n = a_d = 1, ad_oe = 0, busy = 0, done = 0.
2. T_PHASE = 4, bus model returns (latched address + 0x10), one-cycle start at edge k:
   - seg..anio = 0x31..0x36; seg_t, min_t, hora_t = 0x51, 0x52, 0x53.
   - done high only in cycle k+145; busy high for cycles k+1..k+145.
3. Bus-monitor check of test 2:
   - Address order is 0x21..0x26, 0x41..0x43.
   - Each phase is 4 cycles; all invariants hold every cycle.
4. Bus model changes ad_in during READ of 0x22 (0xAA for cycles 0–2, 0x47 on cycle 3) → min = 0x47.
5. start pulses at cycles k+20 and k+145 during the sweep are ignored (exactly one done). start at k+150 launches a second full sweep.
6. reset low asynchronously mid-READ of 0x23 (between edges):
   - Outputs go to reset values immediately, with no clock edge.
   - After release, no bus activity until a new start.
